// File: rtl/mp64_phy_peer_if.sv
// Byte-stream PHY port between the NIC (master) and its link partner (slave).
interface mp64_phy_peer_if;
  logic       nic_tx_valid;
  logic [7:0] nic_tx_data;
  logic       nic_tx_ready;
  logic       nic_rx_valid;
  logic [7:0] nic_rx_data;
  logic       nic_rx_ready;

  modport master (
    output nic_tx_valid,
    output nic_tx_data,
    input  nic_tx_ready,
    input  nic_rx_valid,
    input  nic_rx_data,
    output nic_rx_ready
  );

  modport slave (
    input  nic_tx_valid,
    input  nic_tx_data,
    output nic_tx_ready,
    output nic_rx_valid,
    output nic_rx_data,
    input  nic_rx_ready
  );
endinterface

// File: rtl/mp64_phy_peer.sv
// Link-partner PHY: captures NIC transmit frames, sources injected frames into the
// NIC receive path, and can echo each captured frame back (loopback).
module mp64_phy_peer #(
  parameter int  BUF_DEPTH  = 256,
  parameter int  GAP_CYCLES = 2,
  localparam int AW         = $clog2(BUF_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                link_en_i,
  output logic                link_up_o,
  input  logic                loopback_i,
  mp64_phy_peer_if.slave      nic,
  input  logic [AW-1:0]       cap_rd_addr_i,
  output logic [7:0]          cap_rd_data_o,
  output logic                cap_valid_o,
  output logic [15:0]         cap_len_o,
  output logic                cap_ovf_o,
  input  logic                cap_clr_i,
  input  logic                inj_wr_en_i,
  input  logic [AW-1:0]       inj_wr_addr_i,
  input  logic [7:0]          inj_wr_data_i,
  input  logic [15:0]         inj_len_i,
  input  logic                inj_start_i,
  output logic                inj_busy_o,
  output logic                inj_done_o,
  output logic [15:0]         tx_frames_o,
  output logic [15:0]         rx_frames_o
);

  localparam int          GW     = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(BUF_DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_RECV = 2'd1, C_HOLD = 2'd2} cap_state_e;
  typedef enum logic [1:0] {I_IDLE = 2'd0, I_SEND = 2'd1, I_GAP = 2'd2} inj_state_e;

  logic          link_up_q;

  cap_state_e    cstate_q;
  logic [AW:0]   cnt_q;
  logic          cap_valid_q;
  logic          cap_ovf_q;
  logic          lb_mode_q;
  logic [15:0]   cap_len_q;
  logic [15:0]   tx_frames_q;
  logic [7:0]    cap_rd_data_q;
  logic [7:0]    cap_mem [BUF_DEPTH];

  inj_state_e    istate_q;
  logic [AW:0]   idx_q;
  logic [AW:0]   len_q;
  logic          src_lb_q;
  logic [GW-1:0] gap_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;
  logic          inj_done_q;
  logic [15:0]   rx_frames_q;
  logic [7:0]    inj_mem [BUF_DEPTH];

  logic          tx_ready_s;
  logic          tx_accept_s;
  logic          cap_we_s;
  logic [AW-1:0] cap_wr_addr_s;
  logic          gap_end_s;
  logic          lb_clr_s;
  logic          cap_release_s;
  logic          start_inj_s;
  logic          start_lb_s;
  logic [AW:0]   inj_len_clamped_s;
  logic          src_sel_s;
  logic [AW-1:0] rd_addr_s;
  logic [7:0]    src_byte_s;

  assign tx_ready_s    = link_up_q & (cstate_q != C_HOLD);
  assign tx_accept_s   = nic.nic_tx_valid & tx_ready_s;
  assign cap_we_s      = tx_accept_s & ((cstate_q == C_IDLE) | (cnt_q < DEPTH_W));
  assign cap_wr_addr_s = (cstate_q == C_IDLE) ? '0 : cnt_q[AW-1:0];

  // Gap ends on a live link: in loopback this also releases the held capture.
  assign gap_end_s     = (istate_q == I_GAP) & link_up_q & (gap_q == '0);
  assign lb_clr_s      = gap_end_s & src_lb_q;
  assign cap_release_s = (cstate_q == C_HOLD) & (cap_clr_i | lb_clr_s);

  assign start_lb_s  = (istate_q == I_IDLE) & link_up_q & (cstate_q == C_HOLD) & lb_mode_q;
  assign start_inj_s = (istate_q == I_IDLE) & link_up_q & ~loopback_i & inj_start_i &
                       (inj_len_i != 16'd0);
  assign inj_len_clamped_s = (inj_len_i > 16'(BUF_DEPTH)) ? DEPTH_W : inj_len_i[AW:0];

  // Address and source of the next byte to present on the receive path.
  always_comb begin
    src_sel_s = src_lb_q;
    rd_addr_s = '0;
    if (istate_q == I_IDLE) begin
      src_sel_s = start_lb_s;
      rd_addr_s = '0;
    end else begin
      src_sel_s = src_lb_q;
      rd_addr_s = idx_q[AW-1:0] + AW'(1);
    end
  end

  assign src_byte_s = src_sel_s ? cap_mem[rd_addr_s] : inj_mem[rd_addr_s];

  // Link status follows link_en with one cycle of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_up_q <= 1'b0;
    end else begin
      link_up_q <= link_en_i;
    end
  end

  // Buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (cap_we_s) begin
      cap_mem[cap_wr_addr_s] <= nic.nic_tx_data;
    end
    if (inj_wr_en_i && (istate_q == I_IDLE)) begin
      inj_mem[inj_wr_addr_i] <= inj_wr_data_i;
    end
  end

  // Registered capture-buffer read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_rd_data_q <= 8'd0;
    end else begin
      cap_rd_data_q <= cap_mem[cap_rd_addr_i];
    end
  end

  // Capture FSM: receive a frame, hold it until released.
  always_ff @(posedge clk) begin
    if (rst) begin
      cstate_q    <= C_IDLE;
      cnt_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_ovf_q   <= 1'b0;
      lb_mode_q   <= 1'b0;
      cap_len_q   <= 16'd0;
      tx_frames_q <= 16'd0;
    end else begin
      case (cstate_q)
        C_IDLE: begin
          if (tx_accept_s) begin
            cnt_q    <= ONE_W;
            cstate_q <= C_RECV;
          end
        end
        C_RECV: begin
          if (!link_up_q) begin
            cstate_q <= C_IDLE;
          end else if (nic.nic_tx_valid) begin
            if (cnt_q == DEPTH_W) begin
              cap_ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE_W;
            end
          end else begin
            cstate_q    <= C_HOLD;
            cap_valid_q <= 1'b1;
            cap_len_q   <= 16'(cnt_q);
            tx_frames_q <= tx_frames_q + 16'd1;
            lb_mode_q   <= loopback_i;
          end
        end
        C_HOLD: begin
          if (cap_release_s) begin
            cstate_q    <= C_IDLE;
            cap_valid_q <= 1'b0;
            cap_ovf_q   <= 1'b0;
          end
        end
        default: begin
          cstate_q <= C_IDLE;
        end
      endcase
    end
  end

  // Inject FSM: source a frame without bubbles, then hold valid low for the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      istate_q    <= I_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      src_lb_q    <= 1'b0;
      gap_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'd0;
      inj_done_q  <= 1'b0;
      rx_frames_q <= 16'd0;
    end else begin
      inj_done_q <= 1'b0;
      case (istate_q)
        I_IDLE: begin
          if (start_lb_s || start_inj_s) begin
            istate_q   <= I_SEND;
            idx_q      <= '0;
            src_lb_q   <= start_lb_s;
            len_q      <= start_lb_s ? cap_len_q[AW:0] : inj_len_clamped_s;
            rx_valid_q <= 1'b1;
            rx_data_q  <= src_byte_s;
          end
        end
        I_SEND: begin
          if (!link_up_q) begin
            istate_q   <= I_IDLE;
            rx_valid_q <= 1'b0;
          end else if (nic.nic_rx_ready) begin
            if ((idx_q + ONE_W) == len_q) begin
              istate_q    <= I_GAP;
              rx_valid_q  <= 1'b0;
              gap_q       <= GW'(GAP_CYCLES - 1);
              rx_frames_q <= rx_frames_q + 16'd1;
            end else begin
              idx_q     <= idx_q + ONE_W;
              rx_data_q <= src_byte_s;
            end
          end
        end
        I_GAP: begin
          if (!link_up_q) begin
            istate_q <= I_IDLE;
          end else if (gap_end_s) begin
            istate_q   <= I_IDLE;
            inj_done_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          istate_q   <= I_IDLE;
          rx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign link_up_o        = link_up_q;
  assign nic.nic_tx_ready = tx_ready_s;
  assign nic.nic_rx_valid = rx_valid_q;
  assign nic.nic_rx_data  = rx_data_q;
  assign cap_rd_data_o    = cap_rd_data_q;
  assign cap_valid_o      = cap_valid_q;
  assign cap_len_o        = cap_len_q;
  assign cap_ovf_o        = cap_ovf_q;
  assign inj_busy_o       = (istate_q != I_IDLE);
  assign inj_done_o       = inj_done_q;
  assign tx_frames_o      = tx_frames_q;
  assign rx_frames_o      = rx_frames_q;

endmodule

// File: tb/tb_mp64_phy_peer.sv
// Directed-plus-random bench for mp64_phy_peer against a queue/array reference model.
module tb_mp64_phy_peer;
  localparam int DEPTH = 256;
  localparam int GAP   = 2;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst, link_en, loopback, cap_clr, inj_wr_en, inj_start;
  logic [AW-1:0] cap_rd_addr, inj_wr_addr;
  logic [7:0]    cap_rd_data, inj_wr_data;
  logic          link_up, cap_valid, cap_ovf, inj_busy, inj_done;
  logic [15:0]   cap_len, inj_len, tx_frames, rx_frames;

  mp64_phy_peer_if nic ();

  mp64_phy_peer #(.BUF_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .link_en_i(link_en), .link_up_o(link_up), .loopback_i(loopback),
    .nic(nic), .cap_rd_addr_i(cap_rd_addr), .cap_rd_data_o(cap_rd_data),
    .cap_valid_o(cap_valid), .cap_len_o(cap_len), .cap_ovf_o(cap_ovf), .cap_clr_i(cap_clr),
    .inj_wr_en_i(inj_wr_en), .inj_wr_addr_i(inj_wr_addr), .inj_wr_data_i(inj_wr_data),
    .inj_len_i(inj_len), .inj_start_i(inj_start), .inj_busy_o(inj_busy), .inj_done_o(inj_done),
    .tx_frames_o(tx_frames), .rx_frames_o(rx_frames)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sent  [$];
  logic [7:0] exp_q [$];
  logic [7:0] inj_m [DEPTH];
  int         txf_m = 0;
  int         rxf_m = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_sent(input int n);
    sent = {};
    for (int i = 0; i < n; i++) sent.push_back(8'($urandom_range(0, 255)));
  endtask

  // NIC side: push every byte of 'sent', then drop valid (optionally with cap_clr).
  task automatic nic_send(input bit clr_at_end);
    int to = 0;
    for (int i = 0; i < sent.size(); i++) begin
      int cyc = 0;
      nic.nic_tx_valid = 1'b1;
      nic.nic_tx_data  = sent[i];
      while (nic.nic_tx_ready !== 1'b1 && cyc < 200) begin
        tick();
        cyc++;
      end
      if (cyc >= 200) begin
        to++;
        break;
      end
      tick();
    end
    nic.nic_tx_valid = 1'b0;
    cap_clr = clr_at_end;
    tick();
    cap_clr = 1'b0;
    chk("tx_wait_timeout", to, 0);
  endtask

  task automatic capture_check();
    int n    = sent.size();
    int keep = (n > DEPTH) ? DEPTH : n;
    int a;
    txf_m++;
    chk("cap_valid", cap_valid, 1);
    chk("cap_len", cap_len, keep);
    chk("cap_ovf", cap_ovf, (n > DEPTH) ? 1 : 0);
    chk("tx_frames", tx_frames, txf_m);
    chk("tx_ready_in_hold", nic.nic_tx_ready, 0);
    for (int k = 0; k < ((keep <= 8) ? keep : 4); k++) begin
      if (keep <= 8) a = k;
      else if (k == 0) a = 0;
      else if (k == 1) a = keep - 1;
      else a = $urandom_range(0, keep - 1);
      cap_rd_addr = AW'(a);
      tick();
      chk("cap_rd_data", cap_rd_data, sent[a]);
    end
  endtask

  task automatic release_cap();
    cap_clr = 1'b1;
    tick();
    cap_clr = 1'b0;
    chk("cap_valid_clr", cap_valid, 0);
    chk("cap_ovf_clr", cap_ovf, 0);
    chk("tx_ready_after_clr", nic.nic_tx_ready, 1);
  endtask

  task automatic inj_write(input int a, input logic [7:0] d);
    inj_wr_en   = 1'b1;
    inj_wr_addr = AW'(a);
    inj_wr_data = d;
    tick();
    inj_wr_en = 1'b0;
    inj_m[a] = d;
  endtask

  task automatic inj_go(input int len);
    int n = (len > DEPTH) ? DEPTH : len;
    inj_len   = 16'(len);
    inj_start = 1'b1;
    tick();
    inj_start = 1'b0;
    chk("inj_busy_start", inj_busy, 1);
    chk("rx_valid_start", nic.nic_rx_valid, 1);
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(inj_m[i]);
  endtask

  // NIC receive side: collect exp_q with optional random back-pressure, then check the gap.
  task automatic run_rx(input bit bp);
    int got = 0, cyc = 0, bad = 0, bub = 0;
    bit started = 1'b0;
    while (got < exp_q.size() && cyc < 5000) begin
      nic.nic_rx_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (nic.nic_rx_valid === 1'b1) begin
        started = 1'b1;
        if (nic.nic_rx_data !== exp_q[got]) bad++;
        if (nic.nic_rx_ready) got++;
      end else if (started) begin
        bub++;
      end
      tick();
      cyc++;
    end
    nic.nic_rx_ready = 1'b0;
    rxf_m++;
    chk("rx_byte_count", got, exp_q.size());
    chk("rx_data_errors", bad, 0);
    chk("rx_bubbles", bub, 0);
    for (int g = 0; g < GAP; g++) begin
      chk("gap_valid", nic.nic_rx_valid, 0);
      chk("gap_busy", inj_busy, 1);
      chk("gap_done", inj_done, 0);
      tick();
    end
    chk("inj_done_pulse", inj_done, 1);
    chk("busy_after_gap", inj_busy, 0);
    chk("rx_frames", rx_frames, rxf_m);
    tick();
    chk("inj_done_single", inj_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_seen;
    rst = 1'b1; link_en = 1'b0; loopback = 1'b0; cap_clr = 1'b0;
    inj_wr_en = 1'b0; inj_start = 1'b0; cap_rd_addr = '0; inj_wr_addr = '0;
    inj_wr_data = 8'd0; inj_len = 16'd0;
    nic.nic_tx_valid = 1'b0; nic.nic_tx_data = 8'd0; nic.nic_rx_ready = 1'b0;
    repeat (3) tick();

    chk("rst_link_up", link_up, 0);
    chk("rst_tx_ready", nic.nic_tx_ready, 0);
    chk("rst_rx_valid", nic.nic_rx_valid, 0);
    chk("rst_rx_data", nic.nic_rx_data, 0);
    chk("rst_cap_valid", cap_valid, 0);
    chk("rst_cap_len", cap_len, 0);
    chk("rst_cap_ovf", cap_ovf, 0);
    chk("rst_cap_rd_data", cap_rd_data, 0);
    chk("rst_busy", inj_busy, 0);
    chk("rst_done", inj_done, 0);
    chk("rst_tx_frames", tx_frames, 0);
    chk("rst_rx_frames", rx_frames, 0);

    rst = 1'b0;
    tick();
    chk("link_up_low", link_up, 0);
    link_en = 1'b1;
    tick();
    chk("link_up_high", link_up, 1);
    chk("tx_ready_link", nic.nic_tx_ready, 1);

    // Capture AA BB CC DD; cap_clr coincides with end of frame and must be ignored.
    sent = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    nic_send(1'b1);
    capture_check();
    release_cap();
    repeat (3) begin
      fill_sent($urandom_range(1, 40));
      nic_send(1'b0);
      capture_check();
      release_cap();
    end

    // Inject 11 22 33 44 without back-pressure, then random frames with back-pressure.
    inj_write(0, 8'h11); inj_write(1, 8'h22); inj_write(2, 8'h33); inj_write(3, 8'h44);
    inj_go(4);
    run_rx(1'b0);
    repeat (4) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) inj_write(i, 8'($urandom_range(0, 255)));
      inj_go(n);
      run_rx(1'b1);
    end

    // Write attempt while busy must not alter the frame being sent.
    for (int i = 0; i < 3; i++) inj_write(i, 8'($urandom_range(0, 255)));
    inj_go(3);
    inj_wr_en = 1'b1; inj_wr_addr = 8'd1; inj_wr_data = ~inj_m[1];
    tick();
    inj_wr_en = 1'b0;
    run_rx(1'b1);

    // Overflow: 260 bytes into a 256-byte buffer.
    fill_sent(260);
    nic_send(1'b0);
    capture_check();
    cap_rd_addr = 8'd255;
    tick();
    chk("ovf_last_byte", cap_rd_data, sent[255]);
    release_cap();

    // Loopback sampled at hold entry; dropping loopback afterwards must not cancel the echo.
    loopback = 1'b1;
    fill_sent(5);
    nic_send(1'b0);
    loopback = 1'b0;
    txf_m++;
    chk("lb_cap_valid", cap_valid, 1);
    chk("lb_tx_ready_low", nic.nic_tx_ready, 0);
    exp_q = sent;
    run_rx(1'b1);
    chk("lb_cap_released", cap_valid, 0);
    chk("lb_tx_ready_back", nic.nic_tx_ready, 1);
    chk("lb_tx_frames", tx_frames, txf_m);

    // Ignored starts: loopback high, zero length.
    loopback = 1'b1; inj_len = 16'd4; inj_start = 1'b1;
    tick();
    inj_start = 1'b0; loopback = 1'b0;
    chk("start_ignored_lb", inj_busy, 0);
    inj_len = 16'd0; inj_start = 1'b1;
    tick();
    inj_start = 1'b0;
    chk("start_ignored_len0", inj_busy, 0);

    // Length above the buffer size is clamped.
    for (int i = 0; i < DEPTH; i++) inj_write(i, 8'($urandom_range(0, 255)));
    inj_go(300);
    run_rx(1'b0);

    // Link drop mid-frame at byte 2.
    inj_go(6);
    nic.nic_rx_ready = 1'b1;
    tick();
    tick();
    chk("drop_byte2", nic.nic_rx_data, inj_m[2]);
    link_en = 1'b0;
    tick();
    chk("drop_valid_still", nic.nic_rx_valid, 1);
    tick();
    chk("drop_valid_low", nic.nic_rx_valid, 0);
    chk("drop_busy_low", inj_busy, 0);
    nic.nic_rx_ready = 1'b0;
    inj_len = 16'd3; inj_start = 1'b1;
    tick();
    inj_start = 1'b0;
    chk("start_ignored_link", inj_busy, 0);
    done_seen = 0;
    repeat (5) begin
      if (inj_done === 1'b1) done_seen++;
      tick();
    end
    chk("drop_no_done", done_seen, 0);
    chk("drop_rx_frames", rx_frames, rxf_m);
    chk("drop_link_up", link_up, 0);
    link_en = 1'b1;
    tick();
    tick();
    chk("relink_up", link_up, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
